// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package seq_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Width of the iteration counter, which spans 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// then trial-subtract the divisor from the WIDTH+1-bit partial remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_partial,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] result;
    logic           unused_top;

    assign shifted = {partial, next_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign result  = q_bit ? diff : shifted;

    // The restored remainder is always below the divisor, so its top bit is zero.
    assign next_partial = result[WIDTH-1:0];
    assign unused_top   = result[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional two's-complement mode is compiled in with SEQ_DIV_SIGNED_EN.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] step_part;
    logic             step_q;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // dvd shifts left each step: its MSB feeds the step, quotient bits fill the LSB.
    div_step #(.WIDTH(WIDTH)) u_step (
        .partial     (part),
        .next_bit    (dvd[WIDTH-1]),
        .divisor     (dvs),
        .next_partial(step_part),
        .q_bit       (step_q)
    );

    assign q_raw = {dvd[WIDTH-2:0], step_q};

`ifdef SEQ_DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end

    // Truncation toward zero: remainder follows the dividend's sign.
    assign q_final = neg_q ? -q_raw : q_raw;
    assign r_final = neg_r ? -step_part : step_part;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_mag   = dividend;
    assign b_mag   = divisor;
    assign q_final = q_raw;
    assign r_final = step_part;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; out_valid and the result hold steady until out_ready is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            dvd         <= '0;
            dvs         <= '0;
            part        <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            count <= '0;
                            dvd   <= a_mag;
                            dvs   <= b_mag;
                            part  <= '0;
                        end
                    end
                end
                CALC: begin
                    part  <= step_part;
                    dvd   <= q_raw;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         signed_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .signed_op  (signed_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference result packed as {div_by_zero, quotient, remainder}.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 0) return {1'b1, {W{1'b1}}, a};
`ifdef SEQ_DIV_SIGNED_EN
        if (s) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {1'b0, a, {W{1'b0}}};
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
            return {1'b0, q, r};
        end
`endif
        q = a / b;
        r = a % b;
        return {1'b0, q, r};
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        signed_op = s;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = 1'($urandom_range(0, 1));
    endtask

    // Latency counts the accepting edge as 1.
    task automatic wait_result(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL retire: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, div_by_zero, quotient, remainder} !== {1'b1, 1'b0, 1'b0, {2*W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b dbz=%b q=%h r=%h required 1 0 0 0 0",
                     in_ready, out_valid, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int exp_lat, input logic [2*W:0] exp_res);
        int lat;
        start_op(a, b, s);
        wait_result(lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if ({div_by_zero, quotient, remainder} !== exp_res) begin
            errors++;
            $display("FAIL %s_result: got dbz=%b q=%h r=%h required %h", name,
                     div_by_zero, quotient, remainder, exp_res);
        end
        retire();
    endtask

    task automatic test_reset_mid_calc();
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_calc: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        test_directed("after_reset", 32'd100, 32'd7, 1'b0, W + 1, {1'b0, 32'd14, 32'd2});
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(32'hFFFF_FFFF, 32'h10, 1'b0);
        wait_result(lat);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            checks++;
            if ({out_valid, in_ready, div_by_zero, quotient, remainder} !==
                {1'b1, 1'b0, 1'b0, 32'h0FFF_FFFF, 32'hF}) begin
                errors++;
                $display("FAIL backpressure_hold: out_valid=%b in_ready=%b q=%h r=%h required 1 0 0fffffff f",
                         out_valid, in_ready, quotient, remainder);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        retire();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL backpressure_no_phantom: out_valid=%b in_ready=%b required 0 1",
                         out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [2*W:0] exp;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, W - 1);
            endcase
            s = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, s));
            start_op(a, b, s);
            wait_result(lat);
            checks++;
            if (lat !== ((b == 0) ? 1 : W + 1)) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d for divisor %h", i, lat, b);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            exp = exp_q.pop_front();
            checks++;
            if ({div_by_zero, quotient, remainder} !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL random_result[%0d]: a=%h b=%h s=%b got v=%b dbz=%b q=%h r=%h required %h",
                         i, a, b, s, out_valid, div_by_zero, quotient, remainder, exp);
            end
            retire();
        end
    endtask

`ifdef SEQ_DIV_SIGNED_EN
    task automatic test_signed();
        test_directed("signed_neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, W + 1,
                      {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
        test_directed("signed_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, W + 1,
                      {1'b0, 32'h8000_0000, 32'h0});
        test_directed("signed_div_zero", 32'hFFFF_FFFB, 32'h0, 1'b1, 1,
                      {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB});
        test_directed("signed_7_neg2", 32'd7, 32'hFFFF_FFFE, 1'b1, W + 1,
                      {1'b0, 32'hFFFF_FFFD, 32'd1});
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b0;
        test_reset();
        test_reset_mid_calc();
        test_directed("basic", 32'd100, 32'd7, 1'b0, W + 1, {1'b0, 32'd14, 32'd2});
        test_directed("div_zero", 32'h1234, 32'h0, 1'b0, 1, {1'b1, 32'hFFFF_FFFF, 32'h1234});
        test_backpressure();
        test_directed("small_dividend", 32'd3, 32'd5, 1'b0, W + 1, {1'b0, 32'd0, 32'd3});
        test_directed("max_by_one", 32'hFFFF_FFFF, 32'd1, 1'b0, W + 1, {1'b0, 32'hFFFF_FFFF, 32'd0});
`ifdef SEQ_DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
